philv_fetch_unit: RTL and testbench

//   Instruction fetch stage for the Philosophy-V core. Sits between the instruction

---
 rtl/philv_fetch_pkg.sv | 15 +
 rtl/philv_fetch_fifo.sv | 70 +++++++
 rtl/philv_fetch_unit.sv | 116 +++++++++++
 tb/tb_philv_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/philv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : philv_fetch_pkg
// Purpose  : Shared fetch-stage constants for the Philosophy-V core.
// Revision : 1.0 - initial release
// ============================================================================
package philv_fetch_pkg;

  localparam int unsigned INSTR_WIDTH      = 32;
  localparam logic [31:0] PC_START_ADDRESS = 32'h0000_0000;
  localparam int unsigned PC_INCREMENT     = 4;
  localparam int unsigned FETCH_FIFO_DEPTH = 4;

endpackage : philv_fetch_pkg
`default_nettype wire

// File: rtl/philv_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : philv_fetch_fifo
// Purpose  : Instruction buffer holding (data, pc) pairs; flush beats push/pop.
// Revision : 1.0 - initial release
// ============================================================================
module philv_fetch_fifo
  import philv_fetch_pkg::*;
#(
  parameter int unsigned W     = INSTR_WIDTH,
  parameter int unsigned DEPTH = FETCH_FIFO_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_data,
  input  logic [W-1:0]  i_push_pc,
  input  logic          i_pop,
  output logic [W-1:0]  o_head_data,
  output logic [W-1:0]  o_head_pc,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_data [DEPTH];
  logic [W-1:0]  r_pc   [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign o_count     = r_count;
  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == (AW+1)'(DEPTH));
  assign o_head_data = r_data[r_rd];
  assign o_head_pc   = r_pc[r_rd];

  // A push into a full buffer is only legal when the head leaves the same cycle
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_data[r_wr] <= i_push_data;
      r_pc[r_wr]   <= i_push_pc;
    end
  end

endmodule : philv_fetch_fifo
`default_nettype wire

// File: rtl/philv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : philv_fetch_unit
// Purpose  : PC owner, sequential word fetch, buffered hand-off to decode.
//            Optional macro PHILV_FETCH_BYPASS_EN forwards a returning word
//            straight to decode when the buffer is empty.
// Revision : 1.0 - initial release
// ============================================================================
module philv_fetch_unit
  import philv_fetch_pkg::*;
#(
  parameter int unsigned          BUS_WIDTH  = INSTR_WIDTH,
  parameter int unsigned          FIFO_DEPTH = FETCH_FIFO_DEPTH,
  parameter logic [BUS_WIDTH-1:0] RESET_PC   = BUS_WIDTH'(PC_START_ADDRESS)
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [BUS_WIDTH-1:0] redirect_pc,
  output logic                 mem_req,
  output logic [BUS_WIDTH-1:0] mem_addr,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [BUS_WIDTH-1:0] instr_data,
  output logic [BUS_WIDTH-1:0] instr_pc
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [BUS_WIDTH-1:0] r_pc;
  logic                 r_inflight;
  logic [BUS_WIDTH-1:0] r_tag;

  logic [BUS_WIDTH-1:0] w_head_data;
  logic [BUS_WIDTH-1:0] w_head_pc;
  logic [AW:0]          w_count;
  logic                 w_full;
  logic                 w_empty;
  logic [AW+1:0]        w_committed;
  logic                 w_credit;
  logic                 w_issue;
  logic                 w_bypass;
  logic                 w_push;
  logic                 w_pop;

  // Buffered entries plus the outstanding request must leave a free slot
  assign w_committed = {1'b0, w_count} + {{(AW+1){1'b0}}, r_inflight};
  assign w_credit    = ~w_full & (w_committed < (AW+2)'(FIFO_DEPTH));
  assign w_issue     = rstb & fetch_en & ~redirect_valid & w_credit;

  assign mem_req  = w_issue;
  assign mem_addr = r_pc;

`ifdef PHILV_FETCH_BYPASS_EN
  assign w_bypass = r_inflight & ~redirect_valid & w_empty & instr_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = r_inflight & ~w_bypass;
  assign w_pop  = ~w_empty & instr_ready;

  philv_fetch_fifo #(
    .W     (BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstb        (rstb),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (mem_rdata),
    .i_push_pc   (r_tag),
    .i_pop       (w_pop),
    .o_head_data (w_head_data),
    .o_head_pc   (w_head_pc),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_comb begin
    instr_valid = 1'b0;
    instr_data  = '0;
    instr_pc    = '0;
    if (!w_empty) begin
      instr_valid = 1'b1;
      instr_data  = w_head_data;
      instr_pc    = w_head_pc;
    end else if (w_bypass) begin
      instr_valid = 1'b1;
      instr_data  = mem_rdata;
      instr_pc    = r_tag;
    end
  end

  // Redirect clears the in-flight flag, so the returning word is dropped
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_tag      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_tag <= r_pc;
      if (redirect_valid) begin
        r_pc <= {redirect_pc[BUS_WIDTH-1:2], 2'b00};
      end else if (w_issue) begin
        r_pc <= r_pc + BUS_WIDTH'(PC_INCREMENT);
      end
    end
  end

endmodule : philv_fetch_unit
`default_nettype wire

// File: tb/tb_philv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_philv_fetch_unit
// Purpose  : Self-checking bench for philv_fetch_unit (queue-based reference).
// Revision : 1.0 - initial release
// ============================================================================
module tb_philv_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef PHILV_FETCH_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] mem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  philv_fetch_unit #(
    .BUS_WIDTH  (32),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk            (clk),
    .rstb           (rstb),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: next PC, one outstanding request, buffer as queues
  logic [31:0] m_pc;
  bit          m_infl;
  logic [31:0] m_tag;
  logic [31:0] q_pc[$];
  logic [31:0] q_data[$];
  logic [31:0] key;

  bit          prev_req;
  logic [31:0] prev_addr;
  bit          last_req, last_valid;
  logic [31:0] last_addr, last_pc, last_data;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ key;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = RST_PC;
    m_infl = 1'b0;
    m_tag  = '0;
    q_pc.delete();
    q_data.delete();
  endtask

  task automatic step(input bit rst, input bit en, input bit redir,
                      input logic [31:0] rpc, input bit rdy);
    bit          e_req, e_valid, byp, resp;
    logic [31:0] e_addr, e_data, e_ipc, rd;
    @(posedge clk);
    #1;
    rstb           = ~rst;
    fetch_en       = en;
    redirect_valid = redir;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    mem_rdata      = prev_req ? mem_fn(prev_addr) : $urandom;
    #3;
    if (rst) model_reset();
    resp    = !rst && m_infl;
    rd      = mem_fn(m_tag);
    e_req   = !rst && en && !redir && (q_pc.size() + int'(m_infl) < DEPTH);
    e_addr  = m_pc;
    byp     = BYP && resp && !redir && (q_pc.size() == 0) && rdy;
    e_valid = (q_pc.size() != 0) || byp;
    e_ipc   = (q_pc.size() != 0) ? q_pc[0]   : (byp ? m_tag : 32'h0);
    e_data  = (q_pc.size() != 0) ? q_data[0] : (byp ? rd    : 32'h0);
    chk("mem_req",     32'(mem_req),     32'(e_req));
    chk("mem_addr",    mem_addr,         e_addr);
    chk("instr_valid", 32'(instr_valid), 32'(e_valid));
    chk("instr_pc",    instr_pc,         e_ipc);
    chk("instr_data",  instr_data,       e_data);
    last_req   = mem_req;
    last_addr  = mem_addr;
    last_valid = instr_valid;
    last_pc    = instr_pc;
    last_data  = instr_data;
    prev_req   = mem_req;
    prev_addr  = mem_addr;
    if (!rst) begin
      if (redir) begin
        q_pc.delete();
        q_data.delete();
        m_infl = 1'b0;
        m_pc   = rpc & 32'hFFFF_FFFC;
      end else begin
        if (q_pc.size() != 0 && rdy) begin
          void'(q_pc.pop_front());
          void'(q_data.pop_front());
        end
        if (resp && !byp) begin
          q_pc.push_back(m_tag);
          q_data.push_back(rd);
        end
        if (e_req) begin
          m_infl = 1'b1;
          m_tag  = m_pc;
          m_pc   = m_pc + 32'd4;
        end else begin
          m_infl = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  initial begin
    int  cnt;
    bit  seen, bad;
    model_reset();
    prev_req  = 1'b0;
    prev_addr = '0;
    key       = '0;

    // Reset state and sequential stream with data == address
    do_reset();
    chk("rst_valid", 32'(last_valid), 32'h0);
    chk("rst_req",   32'(last_req),   32'h0);
    chk("rst_addr",  last_addr,       RST_PC);
    chk("rst_pc",    last_pc,         32'h0);
    chk("rst_data",  last_data,       32'h0);
    for (int c = 1; c <= 6; c++) begin
      step(0, 1, 0, 0, 1);
      if (c <= 4) chk("t1_addr", last_addr, 32'(4 * (c - 1)));
      if (c - 1 - LAT >= 0 && c - 1 - LAT <= 2) begin
        chk("t1_valid", 32'(last_valid), 32'h1);
        chk("t1_pc",    last_pc,         32'(4 * (c - 1 - LAT)));
        chk("t1_data",  last_data,       last_pc);
      end
    end

    // Back-pressure fills exactly DEPTH entries, then drains back-to-back
    key = $urandom;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, 0);
      cnt += int'(last_req);
    end
    chk("t2_req_count", 32'(cnt), 32'(DEPTH));
    chk("t2_req_stop",  32'(last_req), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 0, 1);
      if (i < 4) begin
        chk("t2_drain_valid", 32'(last_valid), 32'h1);
        chk("t2_drain_pc",    last_pc,         32'(4 * i));
      end
      if (last_req && !seen) begin
        seen = 1'b1;
        chk("t2_resume_addr", last_addr, 32'h10);
      end
    end
    chk("t2_resume_seen", 32'(seen), 32'h1);

    // Redirect while the request to 0x8 is in flight
    key = $urandom;
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
    step(0, 1, 1, 32'h103, 1);
    chk("t3_redir_req", 32'(last_req), 32'h0);
    bad = last_valid && (last_pc == 32'h8);
    step(0, 1, 0, 0, 1);
    chk("t3_new_req",  32'(last_req), 32'h1);
    chk("t3_new_addr", last_addr,     32'h100);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (last_valid && last_pc == 32'h8) bad = 1'b1;
      if (last_valid && !seen) begin
        seen = 1'b1;
        chk("t3_first_pc", last_pc, 32'h100);
      end
      step(0, 1, 0, 0, 1);
    end
    chk("t3_no_stale", 32'(bad), 32'h0);
    chk("t3_seen",     32'(seen), 32'h1);

    // Redirect coinciding with a valid pop
    key = $urandom;
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 32'h200, 1);
    chk("t4_pop_valid", 32'(last_valid), 32'h1);
    chk("t4_pop_pc",    last_pc,         32'h4);
    seen = 1'b0;
    bad  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 1);
      if (last_valid && last_pc < 32'h200) bad = 1'b1;
      if (last_valid && !seen) begin
        seen = 1'b1;
        chk("t4_first_pc", last_pc, 32'h200);
      end
    end
    chk("t4_no_old", 32'(bad), 32'h0);

    // Asynchronous reset with three buffered entries
    key = $urandom;
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    chk("t5_pre_valid", 32'(last_valid), 32'h1);
    step(1, 1, 0, 0, 1);
    chk("t5_valid", 32'(last_valid), 32'h0);
    chk("t5_req",   32'(last_req),   32'h0);
    chk("t5_addr",  last_addr,       RST_PC);
    step(0, 1, 0, 0, 1);
    chk("t5_restart_req",  32'(last_req), 32'h1);
    chk("t5_restart_addr", last_addr,     RST_PC);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);

    // Single-request latency
    do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("t6_req", 32'(last_req), 32'h1);
    step(0, 0, 0, 0, 1);
    chk("t6_valid_n1", 32'(last_valid), 32'(LAT == 1));
    step(0, 0, 0, 0, 1);
    chk("t6_valid_n2", 32'(last_valid), 32'(LAT == 2));

    // Randomized traffic against the reference
    key = $urandom;
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) < 8,
           $urandom,
           $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_philv_fetch_unit
`default_nettype wire
